// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, SPI mode constants and default sizes
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_TRANSFER = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CS = 4;
  localparam int DEF_DIV_W  = 8;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_cs_if.sv
// rtl/spi_master_cs_if.sv - request/config and serial bus signals of the SPI master
interface spi_master_cs_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CS = DEF_NUM_CS,
  parameter int DIV_W  = DEF_DIV_W
);
  localparam int CS_W = cs_width(NUM_CS);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  clk_div;
  logic              miso;
  logic              mosi;
  logic              sck;
  logic [NUM_CS-1:0] cs_n;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              new_data;

  modport master (
    input  start, data_in, cs_sel, cpol, cpha, lsb_first, clk_div, miso,
    output mosi, sck, cs_n, data_out, busy, new_data
  );

  modport slave (
    output start, data_in, cs_sel, cpol, cpha, lsb_first, clk_div, miso,
    input  mosi, sck, cs_n, data_out, busy, new_data
  );

endinterface

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - half-period counter and SCK edge strobes
module spi_sck_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             xfer_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             lead_edge_o,
  output logic             trail_edge_o,
  output logic             last_edge_o
);
  localparam int EW = $clog2(2 * DATA_W);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    edge_q, edge_d;

  // Wrapping at div_i rather than counting to div_i+1 keeps all-ones legal.
  assign tick_o       = run_i && (cnt_q == div_i);
  assign lead_edge_o  = tick_o && xfer_i && !edge_q[0];
  assign trail_edge_o = tick_o && xfer_i && edge_q[0];
  assign last_edge_o  = (edge_q == EW'(2 * DATA_W - 1));

  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    if (!run_i || tick_o) cnt_d = '0;
    else                  cnt_d = cnt_q + 1'b1;
    if (!xfer_i)     edge_d = '0;
    else if (tick_o) edge_d = edge_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_cs.sv
// rtl/spi_master_cs.sv - single-word SPI master with runtime mode, bit order, divider and chip select
module spi_master_cs
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CS = DEF_NUM_CS,
  parameter int DIV_W  = DEF_DIV_W
) (
  input logic             clk,
  input logic             rst_n,
  spi_master_cs_if.master bus
);
  localparam int CS_W = cs_width(NUM_CS);

  state_e            state_q, state_d;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0]  div_q;
  logic [CS_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, rx_q, data_out_q;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              mosi_q, sck_q, new_data_q;
  logic              accept, done, run, xfer;
  logic              tick, lead, trail, last, drive, sample;

  function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign run  = (state_q != ST_IDLE);
  assign xfer = (state_q == ST_TRANSFER);

  spi_sck_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_sck_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run),
    .xfer_i       (xfer),
    .div_i        (div_q),
    .tick_o       (tick),
    .lead_edge_o  (lead),
    .trail_edge_o (trail),
    .last_edge_o  (last)
  );

  // cpha=0 pre-loads the first bit at accept, so the final trailing edge must not shift.
  assign drive  = cpha_q ? lead : (trail && !last);
  assign sample = cpha_q ? trail : lead;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    sel_d   = sel_q;
    cs_n_d  = '1;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETUP;
          accept  = 1'b1;
          sel_d   = bus.cs_sel;
        end
      end
      ST_SETUP:    if (tick) state_d = ST_TRANSFER;
      ST_TRANSFER: if (tick && last) state_d = ST_HOLD;
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (sel_d == CS_W'(i)) cs_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      sel_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      cs_n_q     <= '1;
      mosi_q     <= 1'b0;
      sck_q      <= 1'b0;
      new_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cs_n_q     <= cs_n_d;
      new_data_q <= done;
      if (done) data_out_q <= rx_q;

      if (accept) begin
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
        lsb_q  <= bus.lsb_first;
        div_q  <= bus.clk_div;
        rx_q   <= '0;
        if (bus.cpha) begin
          tx_q <= bus.data_in;
        end else begin
          mosi_q <= head(bus.data_in, bus.lsb_first);
          tx_q   <= advance(bus.data_in, bus.lsb_first);
        end
      end else if (drive) begin
        mosi_q <= head(tx_q, lsb_q);
        tx_q   <= advance(tx_q, lsb_q);
      end

      if (sample) rx_q <= lsb_q ? {bus.miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso};

      if (state_q == ST_IDLE)  sck_q <= bus.cpol;
      else if (lead || trail)  sck_q <= ~sck_q;
    end
  end

  assign bus.mosi     = mosi_q;
  assign bus.sck      = sck_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = run;
  assign bus.new_data = new_data_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// tb/tb_spi_master_cs.sv - randomized bench for spi_master_cs against a behavioural SPI slave
module tb_spi_master_cs;
  import spi_pkg::*;

  localparam int NCS = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_cs_if #(.DATA_W(8), .NUM_CS(NCS), .DIV_W(8)) bus ();
  spi_master_cs #(.DATA_W(8), .NUM_CS(NCS), .DIV_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  spi_master_cs_if #(.DATA_W(16), .NUM_CS(2), .DIV_W(8)) bus16 ();
  spi_master_cs #(.DATA_W(16), .NUM_CS(2), .DIV_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Slave model configuration, set by the stimulus before each start
  logic           m_pol = 1'b0, m_pha = 1'b0, m_lsb = 1'b0, m_loop = 1'b0;
  logic [7:0]     m_word = 8'h00;
  logic [NCS-1:0] m_exp_cs = '1;

  logic       busy_p = 1'b0, sck_p = 1'b0, lead = 1'b0;
  int         k_tx = 0, k_rx = 0, edges = 0, cs_low = 0, cs_bad = 0, busy_n = 0;
  logic [7:0] cap = 8'h00;

  typedef struct {
    int         cyc;
    logic [7:0] dout;
    logic [7:0] cap;
    int         edges;
    int         cs_low;
    int         cs_bad;
    int         busy_n;
    logic       sck;
  } rec_t;
  rec_t recs[$];

  always @(negedge clk) begin
    rec_t r;
    if (!rst_n) begin
      busy_p   = 1'b0;
      sck_p    = bus.sck;
      edges    = 0;
      bus.miso = 1'b0;
    end else begin
      if (m_loop) bus.miso = bus.mosi;
      if (bus.busy && !busy_p) begin
        k_tx = 0; k_rx = 0; cap = 8'h00; edges = 0; cs_low = 0; cs_bad = 0; busy_n = 0;
        if (!m_loop && !m_pha) begin
          bus.miso = m_lsb ? m_word[k_tx] : m_word[7-k_tx];
          k_tx++;
        end
      end
      if (bus.busy) begin
        busy_n++;
        if (bus.cs_n !== {NCS{1'b1}}) cs_low++;
        if (bus.cs_n !== m_exp_cs) cs_bad++;
        if (busy_p && bus.sck !== sck_p) begin
          edges++;
          lead = (bus.sck !== m_pol);
          if (lead != m_pha) begin
            if (k_rx < 8) begin
              cap[m_lsb ? k_rx : 7-k_rx] = bus.mosi;
              k_rx++;
            end
          end else if (!m_loop && k_tx < 8) begin
            bus.miso = m_lsb ? m_word[k_tx] : m_word[7-k_tx];
            k_tx++;
          end
        end
      end
      if (bus.new_data) begin
        r.cyc = cyc; r.dout = bus.data_out; r.cap = cap; r.edges = edges;
        r.cs_low = cs_low; r.cs_bad = cs_bad; r.busy_n = busy_n; r.sck = bus.sck;
        recs.push_back(r);
      end
      busy_p = bus.busy;
      sck_p  = bus.sck;
    end
  end

  always @(negedge clk) bus16.miso = bus16.mosi;

  task automatic wait_rec(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (recs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_xfer(input string tag, input logic [7:0] din, input logic [2:0] sel,
                         input logic pol, input logic pha, input logic lsb,
                         input logic [7:0] div, input logic [7:0] sw, input bit loop);
    int   h, t0, n0;
    bit   ok;
    rec_t r;
    h = int'(div) + 1;
    m_pol = pol; m_pha = pha; m_lsb = lsb; m_word = sw; m_loop = loop;
    m_exp_cs = (sel < NCS) ? ~(5'b00001 << sel) : 5'h1f;
    bus.data_in = din; bus.cs_sel = sel; bus.cpol = pol; bus.cpha = pha;
    bus.lsb_first = lsb; bus.clk_div = div; bus.start = 1'b1;
    n0 = recs.size();
    step();
    t0 = cyc;
    bus.start = 1'b0;
    check($sformatf("%s busy", tag), bus.busy, 1);
    wait_rec(n0 + 1, 18 * h + 20, ok);
    check($sformatf("%s done", tag), ok, 1);
    if (ok) begin
      r = recs[n0];
      check($sformatf("%s latency", tag), r.cyc - t0, 18 * h);
      check($sformatf("%s data_out", tag), r.dout, loop ? din : sw);
      check($sformatf("%s mosi word", tag), r.cap, din);
      check($sformatf("%s sck edges", tag), r.edges, 16);
      check($sformatf("%s busy cycles", tag), r.busy_n, 18 * h);
      check($sformatf("%s cs low cycles", tag), r.cs_low, (sel < NCS) ? 18 * h : 0);
      check($sformatf("%s cs pattern", tag), r.cs_bad, 0);
      check($sformatf("%s sck idle", tag), r.sck, pol);
    end
  endtask

  logic [1:0]  md;
  logic [15:0] d16;
  int          t0, n0, nd;
  bit          ok;
  rec_t        r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.data_in = 0; bus.cs_sel = 0; bus.cpol = 0; bus.cpha = 0;
    bus.lsb_first = 0; bus.clk_div = 0;
    bus16.start = 0; bus16.data_in = 0; bus16.cs_sel = 0; bus16.cpol = 0; bus16.cpha = 0;
    bus16.lsb_first = 0; bus16.clk_div = 0;
    repeat (3) step();
    check("reset cs_n", bus.cs_n, 5'h1f);
    check("reset busy", bus.busy, 0);
    check("reset new_data", bus.new_data, 0);
    check("reset data_out", bus.data_out, 0);
    check("reset sck", bus.sck, 0);
    check("reset mosi", bus.mosi, 0);
    rst_n = 1'b1;
    step();

    do_xfer("mode0 loop", 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
    md = MODE3;
    do_xfer("mode3 lsb", 8'h3C, 3'd0, md[1], md[0], 1'b1, 8'd0, 8'h81, 1'b0);
    step();
    check("mode3 sck idles high", bus.sck, 1);
    do_xfer("cs2", 8'h96, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h4B, 1'b0);
    do_xfer("cs5", 8'h69, 3'd5, 1'b0, 1'b1, 1'b0, 8'd0, 8'hD2, 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_xfer($sformatf("rand%0d", i), 8'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    end

    // back-to-back start held high; data_in changed while busy
    m_pol = 0; m_pha = 0; m_lsb = 0; m_loop = 0; m_word = 8'h5A; m_exp_cs = 5'h1e;
    bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0; bus.cs_sel = 0; bus.clk_div = 8'd3;
    bus.data_in = 8'hC3; bus.start = 1'b1;
    n0 = recs.size();
    step();
    t0 = cyc;
    bus.data_in = 8'h1E;
    wait_rec(n0 + 1, 100, ok);
    check("b2b first done", ok, 1);
    if (ok) begin
      r = recs[n0];
      check("b2b first latency", r.cyc - t0, 72);
      check("b2b first mosi word", r.cap, 8'hC3);
      check("b2b first data_out", r.dout, 8'h5A);
      check("b2b cs high on new_data", bus.cs_n, 5'h1f);
    end
    step();
    bus.start = 1'b0;
    check("b2b second accepted", bus.busy, 1);
    check("b2b second cs low", bus.cs_n, 5'h1e);
    wait_rec(n0 + 2, 100, ok);
    check("b2b second done", ok, 1);
    if (ok) begin
      r = recs[n0 + 1];
      check("b2b second latency", r.cyc - t0, 145);
      check("b2b second mosi word", r.cap, 8'h1E);
    end

    // reset in the middle of a mode1 transfer
    md = MODE1;
    m_pol = md[1]; m_pha = md[0]; m_lsb = 0; m_loop = 0; m_word = 8'hE7; m_exp_cs = 5'h1d;
    bus.cpol = md[1]; bus.cpha = md[0]; bus.cs_sel = 3'd1; bus.clk_div = 8'd2;
    bus.data_in = 8'h33; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (edges >= 7) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst edge7 reached", ok, 1);
    n0 = recs.size();
    rst_n = 1'b0;
    step();
    check("rst cs_n", bus.cs_n, 5'h1f);
    check("rst busy", bus.busy, 0);
    check("rst data_out", bus.data_out, 0);
    check("rst new_data", bus.new_data, 0);
    check("rst sck", bus.sck, 0);
    bus.cpol = 1'b1;
    rst_n = 1'b1;
    step();
    check("rst release sck follows cpol", bus.sck, 1);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.new_data) nd++;
    end
    check("rst no new_data", nd, 0);
    check("rst no record", recs.size(), n0);
    bus.cpol = 1'b0;

    // 16-bit word with maximum divider
    d16 = 16'($urandom);
    bus16.data_in = d16; bus16.clk_div = 8'hFF; bus16.start = 1'b1;
    step();
    t0 = cyc;
    bus16.start = 1'b0;
    check("h256 busy", bus16.busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 34 * 256 + 20; i++) begin
      step();
      if (bus16.new_data) begin
        ok = 1'b1;
        break;
      end
    end
    check("h256 done", ok, 1);
    if (ok) begin
      check("h256 latency", cyc - t0, 34 * 256);
      check("h256 data_out", bus16.data_out, d16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
